// File: rtl/amp_scheduler.sv
// Round-robin scheduler sharing one amplifier between N_CH sample streams, with a per-channel gain table.
// Optional AMP_SCHED_RAMP_EN: per-channel effective gain steps one code per grant toward the table value.
module amp_scheduler #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [24*N_CH-1:0]   ch_data,
    input  logic [N_CH-1:0]      ch_valid,
    output logic [N_CH-1:0]      ch_ready,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_chan,
    input  logic [3:0]           cfg_gain,
    output logic [23:0]          amp_in_data,
    output logic                 amp_in_valid,
    output logic [3:0]           amp_gain,
    output logic                 amp_out_ready,
    input  logic [23:0]          amp_out_data,
    input  logic                 amp_out_valid,
    output logic [23:0]          out_data,
    output logic [CH_W-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t            state_reg, state_next;
    logic [CH_W-1:0]   last_grant_reg;
    logic [CH_W-1:0]   grant_reg;
    logic [23:0]       sample_reg;
    logic [3:0]        gain_lat_reg;
    logic [23:0]       out_data_reg;
    logic [CH_W-1:0]   out_chan_reg;
    logic              out_valid_reg;
    logic              err_reg;

    logic              grant_found;
    logic [CH_W-1:0]   grant_idx;
    int                rr_idx;
    logic              grant_take;
    logic [4*N_CH-1:0] gain_flat;
    logic [4*N_CH-1:0] issue_gain_flat;

    assign grant_take = (state_reg == IDLE) && grant_found;

    // Search starts one past the last served channel so every requester is reached within N_CH grants.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_idx      = 0;
        for (int i = 1; i <= N_CH; i++) begin
            rr_idx = (int'(last_grant_reg) + i) % N_CH;
            if (!grant_found && ch_valid[rr_idx]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(rr_idx);
            end
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        logic [3:0] gain_reg;

        always_ff @(posedge clk) begin
            if (!reset)
                gain_reg <= 4'b0000;
            else if (cfg_we && cfg_chan == CH_W'(gi))
                gain_reg <= cfg_gain;
        end
        assign gain_flat[4*gi +: 4] = gain_reg;

`ifdef AMP_SCHED_RAMP_EN
        logic [3:0] eff_reg;
        logic [3:0] eff_next;

        // Signed ordering puts mute (1000 = -8) right below -7, so +/-1 steps enter and leave mute via 1001.
        always_comb begin
            eff_next = eff_reg;
            if ($signed(eff_reg) < $signed(gain_reg))
                eff_next = eff_reg + 4'd1;
            else if ($signed(eff_reg) > $signed(gain_reg))
                eff_next = eff_reg - 4'd1;
        end

        always_ff @(posedge clk) begin
            if (!reset)
                eff_reg <= 4'b0000;
            else if (grant_take && grant_idx == CH_W'(gi))
                eff_reg <= eff_next;
        end
        assign issue_gain_flat[4*gi +: 4] = eff_next;
`else
        assign issue_gain_flat[4*gi +: 4] = gain_reg;
`endif
    end

    always_comb begin
        state_next = state_reg;
        ch_ready   = '0;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    ch_ready[grant_idx] = reset;
                    state_next          = ISSUE;
                end
            end
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = amp_out_valid ? OUT : IDLE;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= CH_W'(N_CH - 1);
            grant_reg      <= '0;
            sample_reg     <= '0;
            gain_lat_reg   <= '0;
            out_data_reg   <= '0;
            out_chan_reg   <= '0;
            out_valid_reg  <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        grant_reg    <= grant_idx;
                        sample_reg   <= ch_data[grant_idx*24 +: 24];
                        gain_lat_reg <= issue_gain_flat[grant_idx*4 +: 4];
                    end
                end
                WAIT: begin
                    if (amp_out_valid) begin
                        out_data_reg  <= amp_out_data;
                        out_chan_reg  <= grant_reg;
                        out_valid_reg <= 1'b1;
                    end else begin
                        err_reg        <= 1'b1;
                        last_grant_reg <= grant_reg;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_reg  <= 1'b0;
                        last_grant_reg <= grant_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign amp_in_valid  = (state_reg == ISSUE);
    assign amp_out_ready = (state_reg == ISSUE);
    assign amp_in_data   = (state_reg == ISSUE) ? sample_reg : 24'h0;
    assign amp_gain      = (state_reg == ISSUE) ? gain_lat_reg : 4'h0;
    assign out_data      = out_data_reg;
    assign out_chan      = out_chan_reg;
    assign out_valid     = out_valid_reg;
    assign err           = err_reg;

endmodule

// File: tb/tb_amp_scheduler.sv
// Directed bench for amp_scheduler with a one-cycle behavioural amplifier.
// Expected gains/results switch when built with AMP_SCHED_RAMP_EN.
module tb_amp_scheduler;
    localparam int N_CH = 4;
    localparam int CH_W = 2;

`ifdef AMP_SCHED_RAMP_EN
    localparam logic [3:0]  G1 = 4'b0001;
    localparam logic [23:0] R1 = 24'h000900;
    localparam logic [3:0]  G2 = 4'b1111;
    localparam logic [23:0] R2 = 24'h700000;
`else
    localparam logic [3:0]  G1 = 4'b0010;
    localparam logic [23:0] R1 = 24'h000A00;
    localparam logic [3:0]  G2 = 4'b1000;
    localparam logic [23:0] R2 = 24'h000000;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic [24*N_CH-1:0] ch_data;
    logic [N_CH-1:0]    ch_valid;
    logic [N_CH-1:0]    ch_ready;
    logic               cfg_we;
    logic [CH_W-1:0]    cfg_chan;
    logic [3:0]         cfg_gain;
    logic [23:0]        amp_in_data;
    logic               amp_in_valid;
    logic [3:0]         amp_gain;
    logic               amp_out_ready;
    logic [23:0]        amp_out_data = 24'h0;
    logic               amp_out_valid = 1'b0;
    logic [23:0]        out_data;
    logic [CH_W-1:0]    out_chan;
    logic               out_valid;
    logic               out_ready;
    logic               err;

    logic               amp_drop = 1'b0;
    logic               amp_pend = 1'b0;
    logic [23:0]        amp_res  = 24'h0;

    int checks = 0;
    int errors = 0;

    amp_scheduler #(.N_CH(N_CH), .CH_W(CH_W)) dut (
        .clk(clk), .reset(reset),
        .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_gain(cfg_gain),
        .amp_in_data(amp_in_data), .amp_in_valid(amp_in_valid),
        .amp_gain(amp_gain), .amp_out_ready(amp_out_ready),
        .amp_out_data(amp_out_data), .amp_out_valid(amp_out_valid),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] amp_f(input logic [23:0] x, input logic [3:0] g);
        int xs;
        int gs;
        int r;
        xs = $signed(x);
        gs = $signed(g);
        r  = xs + (xs >>> 3) * gs;
        if (g == 4'b0000) return x;
        if (g == 4'b1000) return 24'h0;
        return r[23:0];
    endfunction

    // Amplifier: accepts in ISSUE, presents its result during the following (WAIT) cycle.
    always @(negedge clk) begin
        amp_out_valid = amp_pend && !amp_drop;
        amp_out_data  = amp_pend ? amp_res : 24'h0;
        amp_pend      = amp_in_valid && amp_out_ready;
        amp_res       = amp_f(amp_in_data, amp_gain);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic cfg(input logic [CH_W-1:0] c, input logic [3:0] g);
        tick();
        cfg_we = 1'b1; cfg_chan = c; cfg_gain = g;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_grant(input int ch, input string tag);
        int cnt;
        cnt = 0;
        while (ch_ready == '0 && cnt < 20) begin
            tick();
            cnt++;
        end
        check(tag, 32'(ch_ready), 32'd1 << ch);
    endtask

    task automatic send(input int ch, input logic [23:0] data,
                        input logic [3:0] exp_gain, input logic [23:0] exp_out);
        int cnt;
        tick();
        ch_data[ch*24 +: 24] = data;
        ch_valid[ch] = 1'b1;
        #1;
        wait_grant(ch, "grant");
        tick();
        ch_valid[ch] = 1'b0;
        check("issue_ctrl", {30'd0, amp_out_ready, amp_in_valid}, 32'd3);
        check("issue_data", 32'(amp_in_data), 32'(data));
        check("issue_gain", 32'(amp_gain), 32'(exp_gain));
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("latency", cnt, 3);
        check("out_data", 32'(out_data), 32'(exp_out));
        check("out_chan", 32'(out_chan), 32'(ch));
        $display("TXN ch %0d in %h gain %h out %h chan %0d", ch, data, amp_gain, out_data, out_chan);
        tick();
    endtask

    initial begin
        int n, cyc, last_cyc, idx, stable, busy, seen;
        reset = 1'b0; ch_data = '0; ch_valid = '1; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_chan = '0; cfg_gain = '0;
        repeat (3) tick();
        check("rst_ch_ready", 32'(ch_ready), 32'd0);
        check("rst_amp", {3'd0, amp_in_valid, amp_out_ready, amp_gain, amp_in_data}, 32'd0);
        check("rst_out", {5'd0, out_valid, err, out_chan, out_data}, 32'd0);
        ch_valid = '0;
        reset = 1'b1;

        send(0, 24'h000100, 4'b0000, 24'h000100);
        cfg(1, 4'b0010);
        send(1, 24'h000800, G1, R1);
        cfg(2, 4'b1000);
        send(2, 24'h7FFFFF, G2, R2);
        send(3, 24'hFFFF00, 4'b0000, 24'hFFFF00);

        // All channels requesting: expect 0,1,2,3,0,1 one grant per 4 cycles.
        tick();
        ch_valid = '1;
        #1;
        n = 0; cyc = 0; last_cyc = 0;
        while (n < 6 && cyc < 60) begin
            if (ch_ready != '0) begin
                idx = 0;
                for (int i = 0; i < N_CH; i++) if (ch_ready[i]) idx = i;
                check("rr_order", idx, n % 4);
                if (n > 0) check("rr_spacing", cyc - last_cyc, 4);
                $display("TXN rr grant %0d to ch %0d at cycle %0d", n, idx, cyc);
                last_cyc = cyc;
                n++;
            end
            tick();
            cyc++;
        end
        check("rr_count", n, 6);
        ch_valid = '0;
        repeat (5) tick();

        // Downstream stall: output held, no new grant while waiting.
        out_ready = 1'b0;
        ch_data[3*24 +: 24] = 24'h000123;
        ch_valid[3] = 1'b1;
        #1;
        wait_grant(3, "stall_grant");
        tick();
        ch_valid[3] = 1'b0;
        ch_data[0 +: 24] = 24'h000040;
        ch_valid[0] = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        stable = 0; busy = 0;
        repeat (10) begin
            tick();
            if (out_valid && out_data == 24'h000123 && out_chan == 2'd3) stable++;
            if (ch_ready != '0) busy++;
        end
        check("stall_stable", stable, 10);
        check("stall_no_grant", busy, 0);
        $display("TXN stall ch 3 out %h held %0d cycles", out_data, stable);
        out_ready = 1'b1;
        tick();
        check("stall_release", 32'(out_valid), 32'd0);
        check("stall_next_grant", 32'(ch_ready), 32'd1);
        tick();
        ch_valid[0] = 1'b0;
        repeat (4) tick();

        // Missing amplifier result: sample dropped, err sticky.
        amp_drop = 1'b1;
        ch_data[1*24 +: 24] = 24'h000321;
        ch_valid[1] = 1'b1;
        #1;
        wait_grant(1, "drop_grant");
        tick();
        ch_valid[1] = 1'b0;
        repeat (2) tick();
        check("drop_err", 32'(err), 32'd1);
        check("drop_no_out", 32'(out_valid), 32'd0);
        $display("TXN drop ch 1 err %0d", err);
        amp_drop = 1'b0;

        // Reset while ch2 is in ISSUE.
        ch_data[2*24 +: 24] = 24'h000555;
        ch_valid[2] = 1'b1;
        #1;
        wait_grant(2, "rst_mid_grant");
        tick();
        check("rst_mid_issue", 32'(amp_in_valid), 32'd1);
        reset = 1'b0;
        ch_valid = '0;
        tick();
        check("rst_mid_amp", {3'd0, amp_in_valid, amp_out_ready, amp_gain, amp_in_data}, 32'd0);
        check("rst_mid_out", {5'd0, out_valid, err, out_chan, out_data}, 32'd0);
        reset = 1'b1;
        seen = 0;
        repeat (6) begin
            tick();
            if (out_valid) seen++;
        end
        check("rst_mid_no_out", seen, 0);
        ch_valid = 4'b0101;
        #1;
        check("rst_mid_next_grant", 32'(ch_ready), 32'd1);
        $display("TXN reset mid-issue next grant %b", ch_ready);
        tick();
        ch_valid = '0;
        repeat (4) tick();

`ifdef AMP_SCHED_RAMP_EN
        cfg(0, 4'b0011);
        send(0, 24'h000800, 4'b0001, 24'h000900);
        send(0, 24'h000800, 4'b0010, 24'h000A00);
        send(0, 24'h000800, 4'b0011, 24'h000B00);
        send(0, 24'h000800, 4'b0011, 24'h000B00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
